// File: rtl/nibble_batch_loader.sv
// Packs a valid/ready stream of 4-bit values into 8-slot batches for the adder tree.
// A batch closes on the 8th nibble or on in_last. Unfilled slots are zero-padded.
module nibble_batch_loader #(
  parameter int unsigned ISSUE_GAP = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] in_data_i,
  input  logic       in_valid_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic [3:0] input_val0_o,
  output logic [3:0] input_val1_o,
  output logic [3:0] input_val2_o,
  output logic [3:0] input_val3_o,
  output logic [3:0] input_val4_o,
  output logic [3:0] input_val5_o,
  output logic [3:0] input_val6_o,
  output logic [3:0] input_val7_o,
  output logic       s_vi_o,
  output logic [7:0] batch_cnt_o,
  output logic [3:0] fill_level_o
);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_GAP   = 1'b1;
  localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP);

  logic [0:0] state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] col_q [8];
  logic [3:0] col_d [8];
  logic [3:0] out_q [8];
  logic [3:0] out_d [8];
  logic       s_vi_q, s_vi_d;
  logic [7:0] batch_q, batch_d;
  logic       accept;
  logic       closing;

  // Ready is forced low while reset is asserted so nothing is handshaken into a discarded batch.
  assign in_ready_o = (state_q == ST_FILL) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign closing    = accept && ((idx_q == 3'd7) || in_last_i);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    col_d   = col_q;
    out_d   = out_q;
    s_vi_d  = 1'b0;
    batch_d = batch_q;
    if (state_q == ST_GAP) begin
      gap_d = gap_q - 4'd1;
      if (gap_q <= 4'd1) state_d = ST_FILL;
    end else if (closing) begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) < idx_q)       out_d[i] = col_q[i];
        else if (3'(i) == idx_q) out_d[i] = in_data_i;
        else                     out_d[i] = 4'd0;
        col_d[i] = 4'd0;
      end
      idx_d   = 3'd0;
      s_vi_d  = 1'b1;
      batch_d = batch_q + 8'd1;
      if (GAP_LOAD != 4'd0) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
    end else if (accept) begin
      col_d[idx_q] = in_data_i;
      idx_d        = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      gap_q   <= 4'd0;
      idx_q   <= 3'd0;
      s_vi_q  <= 1'b0;
      batch_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        col_q[i] <= 4'd0;
        out_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      s_vi_q  <= s_vi_d;
      batch_q <= batch_d;
      col_q   <= col_d;
      out_q   <= out_d;
    end
  end

  assign input_val0_o = out_q[0];
  assign input_val1_o = out_q[1];
  assign input_val2_o = out_q[2];
  assign input_val3_o = out_q[3];
  assign input_val4_o = out_q[4];
  assign input_val5_o = out_q[5];
  assign input_val6_o = out_q[6];
  assign input_val7_o = out_q[7];
  assign s_vi_o       = s_vi_q;
  assign batch_cnt_o  = batch_q;
  assign fill_level_o = {1'b0, idx_q};

endmodule

// File: tb/tb_nibble_batch_loader.sv
// Drives two loaders (gap 0 and gap 3) with shared stimulus and compares them to a
// batch-level reference model: pending nibble list, gap countdown, issued-batch count.
module tb_nibble_batch_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic [3:0] in_data;
  logic       rdy [2];
  logic       sv  [2];
  logic [7:0] bc  [2];
  logic [3:0] fl  [2];
  logic [3:0] v   [2][8];

  always #5 clk = ~clk;

  nibble_batch_loader #(.ISSUE_GAP(0)) u_g0 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(rdy[0]),
    .input_val0_o(v[0][0]), .input_val1_o(v[0][1]), .input_val2_o(v[0][2]), .input_val3_o(v[0][3]),
    .input_val4_o(v[0][4]), .input_val5_o(v[0][5]), .input_val6_o(v[0][6]), .input_val7_o(v[0][7]),
    .s_vi_o(sv[0]), .batch_cnt_o(bc[0]), .fill_level_o(fl[0])
  );

  nibble_batch_loader #(.ISSUE_GAP(3)) u_g3 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(rdy[1]),
    .input_val0_o(v[1][0]), .input_val1_o(v[1][1]), .input_val2_o(v[1][2]), .input_val3_o(v[1][3]),
    .input_val4_o(v[1][4]), .input_val5_o(v[1][5]), .input_val6_o(v[1][6]), .input_val7_o(v[1][7]),
    .s_vi_o(sv[1]), .batch_cnt_o(bc[1]), .fill_level_o(fl[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state, one entry per instance
  int         gap_cfg [2] = '{0, 3};
  logic [3:0] m_hold  [2][8];
  int         m_fill  [2];
  logic [3:0] m_out   [2][8];
  bit         m_strobe[2];
  int         m_issued[2];
  int         m_wait  [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_fill[k] = 0; m_strobe[k] = 0; m_issued[k] = 0; m_wait[k] = 0;
        for (int j = 0; j < 8; j++) m_out[k][j] = 4'd0;
      end else begin
        m_strobe[k] = 0;
        if (m_wait[k] > 0) m_wait[k]--;
        else if (in_valid) begin
          m_hold[k][m_fill[k]] = in_data;
          m_fill[k]++;
          if (m_fill[k] == 8 || in_last) begin
            for (int j = 0; j < 8; j++) m_out[k][j] = (j < m_fill[k]) ? m_hold[k][j] : 4'd0;
            m_fill[k]   = 0;
            m_strobe[k] = 1;
            m_issued[k] = (m_issued[k] + 1) % 256;
            m_wait[k]   = gap_cfg[k];
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] pack_dut(int k);
    logic [31:0] r;
    for (int j = 0; j < 8; j++) r[4*j +: 4] = v[k][j];
    return r;
  endfunction

  function automatic logic [31:0] pack_model(int k);
    logic [31:0] r;
    for (int j = 0; j < 8; j++) r[4*j +: 4] = m_out[k][j];
    return r;
  endfunction

  function automatic int sum_dut(int k);
    int s = 0;
    for (int j = 0; j < 8; j++) s += int'(v[k][j]);
    return s;
  endfunction

  task automatic step(input bit vld, input logic [3:0] d, input bit lst, input bit r);
    @(negedge clk);
    rst = r; in_valid = vld; in_data = d; in_last = lst;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("ready_g%0d", gap_cfg[k]), 32'(rdy[k]), 32'(!r && m_wait[k] == 0));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("s_vi_g%0d", gap_cfg[k]), 32'(sv[k]), 32'(m_strobe[k]));
      check($sformatf("batch_cnt_g%0d", gap_cfg[k]), 32'(bc[k]), 32'(m_issued[k]));
      check($sformatf("fill_level_g%0d", gap_cfg[k]), 32'(fl[k]), 32'(m_fill[k]));
      check($sformatf("slots_g%0d", gap_cfg[k]), pack_dut(k), pack_model(k));
    end
  endtask

  logic [3:0] pat [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 4'd0;
    for (int k = 0; k < 2; k++) begin
      m_fill[k] = 0; m_strobe[k] = 0; m_issued[k] = 0; m_wait[k] = 0;
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("reset_cnt", 32'(bc[0]), 32'd0);

    // Full batch
    pat = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd2};
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0);
    check("full_strobe", 32'(sv[0]), 32'd1);
    check("full_sum39", 32'(sum_dut(0)), 32'd39);
    check("full_cnt", 32'(bc[0]), 32'd1);
    step(0, 0, 0, 0);
    check("strobe_one_cycle", 32'(sv[0]), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Short batch closed by in_last
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 1, 0);
    check("short_slots", pack_dut(0), 32'h0000_0444);
    check("short_fill", 32'(fl[0]), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Back-pressure: gap-3 instance stalls the stream
    for (int i = 0; i < 24; i++) step(1, 3, 0, 0);
    check("bp_sum24", 32'(sum_dut(1)), 32'd24);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Stalled source, 1..8 on alternate cycles
    for (int i = 0; i < 16; i++) step(i % 2 == 0, 4'(i / 2 + 1), 0, 0);
    check("stall_slots", pack_dut(0), 32'h8765_4321);

    // Reset mid-batch
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 15, 0, 0);
    check("reset_sum120", 32'(sum_dut(0)), 32'd120);

    // Counter wrap with single-nibble batches
    step(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(1, 4'(i), 1, 0);
    check("wrap_cnt", 32'(bc[0]), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
